i2s_tdm_rx: RTL and testbench

I2S_TDM_RX -- requirements
Module: i2s_tdm_rx

---
 rtl/i2s_tdm_rx.sv | 143 ++++++++++++++
 tb/tb_i2s_tdm_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tdm_rx
// Description : I2S / left-justified / TDM serial audio receiver. Oversamples
//               bclk, lrclk and sdata in the clk_i domain, tracks bit position
//               within the frame, deserialises NUM_CH signed samples and
//               presents them as one parallel frame with a valid strobe.
//               Framing errors (early frame start or a lost frame sync) are
//               reported with a one-clk strobe.
// Ports       : clk_i       - system clock (>= 8x bclk rate)
//               rst_i       - asynchronous active-high reset
//               bclk_i      - serial bit clock (asynchronous)
//               lrclk_i     - frame sync (I2S LR clock or TDM sync pulse)
//               sdata_i     - serial data, MSB first
//               audio_o     - channel c at [c*DATA_W +: DATA_W]
//               valid_o     - one-clk strobe, new audio_o frame
//               frame_err_o - one-clk strobe, framing error
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_rx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int NUM_CH = 2,
  parameter int MODE   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     bclk_i,
  input  logic                     lrclk_i,
  input  logic                     sdata_i,
  output logic [NUM_CH*DATA_W-1:0] audio_o,
  output logic                     valid_o,
  output logic                     frame_err_o
);

  localparam int FRAME_BITS = NUM_CH * SLOT_W;
  localparam int CNT_W      = $clog2(2 * FRAME_BITS);
  localparam int OFFS       = (MODE == 0) ? 1 : 0;

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 * FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'((NUM_CH - 1) * SLOT_W + DATA_W - 1 + OFFS);

  logic [1:0]               bclk_sync;
  logic [1:0]               lrclk_sync;
  logic [1:0]               sdata_sync;
  logic                     bclk_d;
  logic                     lrclk_prev;
  logic                     locked;
  logic                     last_cap;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         pos;
  logic [NUM_CH*DATA_W-1:0] shadow;
  logic [NUM_CH-1:0]        slot_hit;
  logic                     bclk_rise;
  logic                     frame_start;
  logic                     cap_en;

  assign bclk_rise   = bclk_sync[1] & ~bclk_d;
  assign frame_start = bclk_rise & ~lrclk_sync[1] & lrclk_prev;
  // Captures are allowed on the relocking rise itself so that a
  // left-justified MSB sitting on the frame edge is not lost.
  assign cap_en      = bclk_rise & (locked | frame_start);

  // Position of the bit being sampled on this rise: a frame start always
  // wins and names the current bit position 0.
  always_comb begin
    pos = cnt;
    if (frame_start) begin
      pos = '0;
    end else if (cnt != CNT_SAT) begin
      pos = cnt + 1'b1;
    end
  end

  // Per-slot capture window: DATA_W positions starting at the slot's MSB.
  for (genvar s = 0; s < NUM_CH; s++) begin : g_slot
    localparam logic [CNT_W-1:0] LO = CNT_W'(s * SLOT_W + OFFS);
    localparam logic [CNT_W-1:0] HI = CNT_W'(s * SLOT_W + OFFS + DATA_W);
    assign slot_hit[s] = (pos >= LO) && (pos < HI);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_sync   <= '0;
      lrclk_sync  <= '0;
      sdata_sync  <= '0;
      bclk_d      <= 1'b0;
      lrclk_prev  <= 1'b0;
      locked      <= 1'b0;
      last_cap    <= 1'b0;
      cnt         <= '0;
      shadow      <= '0;
      audio_o     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      bclk_sync   <= {bclk_sync[0], bclk_i};
      lrclk_sync  <= {lrclk_sync[0], lrclk_i};
      sdata_sync  <= {sdata_sync[0], sdata_i};
      bclk_d      <= bclk_sync[1];
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      last_cap    <= 1'b0;

      // Publish the frame one clk after the final LSB landed in shadow.
      if (last_cap) begin
        audio_o <= shadow;
        valid_o <= 1'b1;
      end

      if (bclk_rise) begin
        lrclk_prev <= lrclk_sync[1];
        cnt        <= pos;

        if (frame_start) begin
          // Unlocked starts (first after reset or after loss) never flag.
          if (locked && (cnt != CNT_END)) begin
            frame_err_o <= 1'b1;
          end
          locked <= 1'b1;
        end else if (locked && (pos == CNT_SAT) && (cnt != CNT_SAT)) begin
          // Two frames' worth of bits with no sync: sync is lost.
          frame_err_o <= 1'b1;
          locked      <= 1'b0;
        end

        if (cap_en && (pos == LAST_POS)) begin
          last_cap <= 1'b1;
        end

        for (int s = 0; s < NUM_CH; s++) begin
          if (cap_en && slot_hit[s]) begin
            shadow[s*DATA_W +: DATA_W] <=
              (shadow[s*DATA_W +: DATA_W] << 1) | DATA_W'(sdata_sync[1]);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tdm_rx
// Description : Directed self-checking bench for i2s_tdm_rx. One instance in
//               default I2S stereo form, one in 8-slot left-justified TDM form.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bclk1 = 1'b0, lr1 = 1'b0, sd1 = 1'b0;
  logic        bclk2 = 1'b0, lr2 = 1'b0, sd2 = 1'b0;
  logic [47:0] audio1;
  logic        valid1, err1;
  logic [191:0] audio2;
  logic        valid2, err2;

  int tests = 0;
  int fails = 0;
  int vcnt1 = 0, ecnt1 = 0, vcnt2 = 0, ecnt2 = 0;

  always #5 clk = ~clk;

  i2s_tdm_rx u_dut (
    .clk_i(clk), .rst_i(rst), .bclk_i(bclk1), .lrclk_i(lr1), .sdata_i(sd1),
    .audio_o(audio1), .valid_o(valid1), .frame_err_o(err1)
  );

  i2s_tdm_rx #(.DATA_W(24), .SLOT_W(32), .NUM_CH(8), .MODE(1)) u_tdm (
    .clk_i(clk), .rst_i(rst), .bclk_i(bclk2), .lrclk_i(lr2), .sdata_i(sd2),
    .audio_o(audio2), .valid_o(valid2), .frame_err_o(err2)
  );

  always @(negedge clk) begin
    if (valid1) vcnt1++;
    if (err1)   ecnt1++;
    if (valid2) vcnt2++;
    if (err2)   ecnt2++;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    bclk1 = 1'b0; lr1 = 1'b0; sd1 = 1'b0;
    bclk2 = 1'b0; lr2 = 1'b0; sd2 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    vcnt1 = 0; ecnt1 = 0; vcnt2 = 0; ecnt2 = 0;
  endtask

  task automatic bit1(input logic lr, input logic d);
    lr1 = lr; sd1 = d; bclk1 = 1'b0;
    repeat (4) @(posedge clk);
    bclk1 = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic bit2(input logic lr, input logic d);
    lr2 = lr; sd2 = d; bclk2 = 1'b0;
    repeat (4) @(posedge clk);
    bclk2 = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // I2S stereo frame positions first..last (64-bit frame, MSB one bit late).
  task automatic frame1(input logic [23:0] l, input logic [23:0] r,
                        input int first, input int last);
    for (int p = first; p <= last; p++) begin
      int k;
      logic [23:0] w;
      logic d;
      k = (p % 32) - 1;
      w = (p >= 32) ? r : l;
      d = (k >= 0 && k < 24) ? w[23-k] : 1'b0;
      bit1(p >= 32, d);
    end
  endtask

  // 8-slot TDM frame, slot s = 0x010101*s, sync pulse on the last bit.
  task automatic frame2();
    for (int p = 0; p < 256; p++) begin
      int k;
      logic [23:0] w;
      logic d;
      k = p % 32;
      w = 24'h010101 * (p / 32);
      d = (k < 24) ? w[23-k] : 1'b0;
      bit2(p == 255, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++;
    if (audio1 !== 48'h0 || valid1 !== 1'b0 || err1 !== 1'b0) begin
      $display("FAIL reset_state: audio=%h valid=%b err=%b, required 0/0/0", audio1, valid1, err1);
      fails++;
    end
    do_reset();
    tests++;
    if (audio2 !== 192'h0 || valid2 !== 1'b0 || err2 !== 1'b0) begin
      $display("FAIL reset_state_tdm: audio=%h valid=%b err=%b, required 0", audio2, valid2, err2);
      fails++;
    end
  endtask

  task automatic test_i2s_basic();
    do_reset();
    repeat (4) frame1(24'h123456, 24'hABCDEF, 0, 63);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (audio1 !== 48'hABCDEF_123456) begin
      $display("FAIL i2s_audio: got %h, required %h", audio1, 48'hABCDEF_123456);
      fails++;
    end
    tests++;
    if (vcnt1 !== 3) begin
      $display("FAIL i2s_valid_count: got %0d, required 3", vcnt1);
      fails++;
    end
    tests++;
    if (ecnt1 !== 0) begin
      $display("FAIL i2s_err_count: got %0d, required 0", ecnt1);
      fails++;
    end
  endtask

  task automatic test_tdm8();
    logic [23:0] lane;
    do_reset();
    repeat (3) frame2();
    repeat (10) @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      lane = audio2[c*24 +: 24];
      tests++;
      if (lane !== 24'(24'h010101 * c)) begin
        $display("FAIL tdm_lane%0d: got %h, required %h", c, lane, 24'(24'h010101 * c));
        fails++;
      end
    end
    tests++;
    if (vcnt2 !== 2 || ecnt2 !== 0) begin
      $display("FAIL tdm_counts: valid=%0d err=%0d, required 2/0", vcnt2, ecnt2);
      fails++;
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    frame1(24'h111111, 24'h222222, 0, 63);
    frame1(24'h111111, 24'h222222, 0, 63);
    frame1(24'h111111, 24'h222222, 0, 62);
    repeat (10) @(posedge clk);
    tests++;
    if (ecnt1 !== 0) begin
      $display("FAIL short_no_early_err: got %0d, required 0", ecnt1);
      fails++;
    end
    frame1(24'h5A5A5A, 24'h800001, 0, 63);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (ecnt1 !== 1) begin
      $display("FAIL short_err_count: got %0d, required 1", ecnt1);
      fails++;
    end
    tests++;
    if (audio1 !== 48'h800001_5A5A5A || vcnt1 !== 3) begin
      $display("FAIL short_recover: audio=%h valid=%0d, required %h/3", audio1, vcnt1, 48'h800001_5A5A5A);
      fails++;
    end
  endtask

  task automatic test_stuck_low();
    int v0;
    do_reset();
    frame1(24'h123456, 24'hABCDEF, 0, 63);
    frame1(24'h123456, 24'hABCDEF, 0, 63);
    repeat (128) bit1(1'b0, 1'b0);
    repeat (10) @(posedge clk);
    tests++;
    if (ecnt1 !== 1) begin
      $display("FAIL stuck_err_at_127: got %0d, required 1", ecnt1);
      fails++;
    end
    v0 = vcnt1;
    repeat (72) bit1(1'b0, 1'b1);
    repeat (32) bit1(1'b1, 1'b1);
    repeat (10) @(posedge clk);
    tests++;
    if (vcnt1 !== v0 || ecnt1 !== 1) begin
      $display("FAIL stuck_quiet: valid=%0d err=%0d, required %0d/1", vcnt1, ecnt1, v0);
      fails++;
    end
    frame1(24'h0F0F0F, 24'hF0F0F0, 0, 63);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (vcnt1 !== v0 + 1 || audio1 !== 48'hF0F0F0_0F0F0F || ecnt1 !== 1) begin
      $display("FAIL stuck_relock: valid=%0d audio=%h err=%0d, required %0d/%h/1",
               vcnt1, audio1, ecnt1, v0 + 1, 48'hF0F0F0_0F0F0F);
      fails++;
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    frame1(24'h123456, 24'hABCDEF, 0, 63);
    frame1(24'h123456, 24'hABCDEF, 0, 63);
    frame1(24'h999999, 24'h777777, 0, 40);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (audio1 !== 48'h0 || valid1 !== 1'b0) begin
      $display("FAIL async_reset: audio=%h valid=%b, required 0/0", audio1, valid1);
      fails++;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vcnt1 = 0; ecnt1 = 0;
    frame1(24'h999999, 24'h777777, 41, 63);
    repeat (10) @(posedge clk);
    tests++;
    if (vcnt1 !== 0 || audio1 !== 48'h0) begin
      $display("FAIL reset_discard: valid=%0d audio=%h, required 0/0", vcnt1, audio1);
      fails++;
    end
    frame1(24'h654321, 24'hFEDCBA, 0, 63);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (vcnt1 !== 1 || audio1 !== 48'hFEDCBA_654321 || ecnt1 !== 0) begin
      $display("FAIL reset_resume: valid=%0d audio=%h err=%0d, required 1/%h/0",
               vcnt1, audio1, ecnt1, 48'hFEDCBA_654321);
      fails++;
    end
  endtask

  task automatic test_lrclk_low();
    do_reset();
    for (int i = 0; i < 200; i++) bit1(1'b0, 1'($urandom_range(0, 1)));
    repeat (10) @(posedge clk);
    tests++;
    if (vcnt1 !== 0 || ecnt1 !== 0) begin
      $display("FAIL lrclk_low_quiet: valid=%0d err=%0d, required 0/0", vcnt1, ecnt1);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_i2s_basic();
    test_tdm8();
    test_short_frame();
    test_stuck_low();
    test_reset_midframe();
    test_lrclk_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
